// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if
//   Bundles the lookup side and the refill side of set_assoc_cache.
//   Lookup : search_cache, address, flush in; busy, search_done, hit, data,
//            tag_out out.
//   Refill : mem_req, RAM_address out; mem_valid, main_memory_data in.
//   The slave modport is the cache; the master modport is requester plus memory.
interface set_assoc_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SETS   = 512
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  logic              search_cache;
  logic [ADDR_W-1:0] address;
  logic              flush;
  logic              busy;
  logic              search_done;
  logic              hit;
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag_out;
  logic              mem_req;
  logic [ADDR_W-1:0] RAM_address;
  logic              mem_valid;
  logic [DATA_W-1:0] main_memory_data;

  modport slave (
    input  search_cache, address, flush, mem_valid, main_memory_data,
    output busy, search_done, hit, data, tag_out, mem_req, RAM_address
  );

  modport master (
    output search_cache, address, flush, mem_valid, main_memory_data,
    input  busy, search_done, hit, data, tag_out, mem_req, RAM_address
  );
endinterface

// File: rtl/set_assoc_cache.sv
// set_assoc_cache
//   N-way set-associative read-only cache with a single-word line. A lookup
//   hits in one cycle; a miss issues a refill over mem_req/mem_valid and fills
//   the lowest invalid way, or else the way at the set's round-robin pointer.
//   flush invalidates every line in one cycle.
// Ports:
//   clock        - sole clock, rising edge
//   reset        - asynchronous, active-high
//   bus          - set_assoc_cache_if.slave (lookup and refill signals)
//   hit_count    - 32-bit saturating hit counter   (only with CACHE_STATS_EN)
//   miss_count   - 32-bit saturating miss counter  (only with CACHE_STATS_EN)
// Optional feature macro: CACHE_STATS_EN
module set_assoc_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SETS   = 512,
  parameter int WAYS   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  set_assoc_cache_if.slave       bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t            state_r;
  logic [TAG_W-1:0]  req_tag_r;
  logic [IDX_W-1:0]  req_idx_r;

  logic [WAYS-1:0]   valid_r    [SETS];
  logic [WAY_W-1:0]  ptr_r      [SETS];
  logic [TAG_W-1:0]  tag_mem_r  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem_r [SETS][WAYS];

  logic              hit_s;
  logic [DATA_W-1:0] hit_data_s;
  logic [WAY_W-1:0]  victim_s;
  logic              any_invalid_s;
  logic              refill_fire_s;
  logic              unused_offset_s;

  // The byte offset within a line never selects anything.
  assign unused_offset_s = ^bus.address[OFF_W-1:0];

  assign refill_fire_s = (state_r == REFILL) && bus.mem_valid;

  // Tag compare across the indexed set and victim choice for a refill.
  always_comb begin
    hit_s         = 1'b0;
    hit_data_s    = {DATA_W{1'b0}};
    victim_s      = ptr_r[req_idx_r];
    any_invalid_s = 1'b0;
    // Walk downwards so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_r[req_idx_r][w]) begin
        victim_s      = WAY_W'(w);
        any_invalid_s = 1'b1;
      end else begin
        any_invalid_s = any_invalid_s;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[req_idx_r][w] && (tag_mem_r[req_idx_r][w] == req_tag_r)) begin
        hit_s      = 1'b1;
        hit_data_s = data_mem_r[req_idx_r][w];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Line storage write on a completed refill (array carries no reset).
  always_ff @(posedge clock) begin
    if (refill_fire_s) begin
      tag_mem_r[req_idx_r][victim_s]  <= req_tag_r;
      data_mem_r[req_idx_r][victim_s] <= bus.main_memory_data;
    end
  end

  // Control FSM with registered outputs, valid bits and replacement pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      req_tag_r        <= {TAG_W{1'b0}};
      req_idx_r        <= {IDX_W{1'b0}};
      bus.busy         <= 1'b0;
      bus.search_done  <= 1'b0;
      bus.hit          <= 1'b0;
      bus.data         <= {DATA_W{1'b0}};
      bus.tag_out      <= {TAG_W{1'b0}};
      bus.mem_req      <= 1'b0;
      bus.RAM_address  <= {ADDR_W{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        ptr_r[s]   <= {WAY_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          bus.search_done <= 1'b0;
          // Accepting here also covers the edge ending a search_done cycle.
          if (bus.flush) begin
            bus.busy <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
              valid_r[s] <= {WAYS{1'b0}};
            end
          end else if (bus.search_cache) begin
            req_tag_r <= bus.address[ADDR_W-1 -: TAG_W];
            req_idx_r <= bus.address[OFF_W +: IDX_W];
            bus.busy  <= 1'b1;
            state_r   <= LOOKUP;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            bus.search_done <= 1'b1;
            bus.hit         <= 1'b1;
            bus.data        <= hit_data_s;
            bus.tag_out     <= req_tag_r;
            state_r         <= IDLE;
          end else begin
            bus.mem_req     <= 1'b1;
            bus.RAM_address <= {req_tag_r, req_idx_r, {OFF_W{1'b0}}};
            state_r         <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_valid) begin
            valid_r[req_idx_r][victim_s] <= 1'b1;
            // Pointer only advances when an already-valid line is evicted.
            if (!any_invalid_s) begin
              ptr_r[req_idx_r] <= (ptr_r[req_idx_r] == WAY_W'(WAYS - 1)) ?
                                  {WAY_W{1'b0}} : ptr_r[req_idx_r] + WAY_W'(1);
            end else begin
              ptr_r[req_idx_r] <= ptr_r[req_idx_r];
            end
            bus.mem_req     <= 1'b0;
            bus.search_done <= 1'b1;
            bus.hit         <= 1'b0;
            bus.data        <= bus.main_memory_data;
            bus.tag_out     <= req_tag_r;
            state_r         <= IDLE;
          end else begin
            state_r <= REFILL;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, stepped on the completion edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if ((state_r == LOOKUP) && hit_s && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (refill_fire_s && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
